// File: rtl/trng_pkg.sv
// trng_pkg: shared constants for the multi-source TRNG.
//   - register word offsets (decoded from ADDR_I[3:2])
//   - CTRL / STATUS bit positions
//   - scan-mode LFSR seed, tap mask and next-state helper
//   - output word width
package trng_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DATA   = 2'd2;
  localparam logic [1:0] ADDR_REP    = 2'd3;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_HFAIL     = 2;
  localparam int ST_UNDF      = 3;
  localparam int ST_LEVEL_LSB = 8;

  // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Fibonacci form:
  // feedback = s[0] ^ s[2] ^ s[3] ^ s[5], inserted at bit 15.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/trng_fifo.sv
// trng_fifo: synchronous FIFO with flush.
//   clk, rst_n  clock, asynchronous active-low reset
//   flush       empties the FIFO; wins over push and pop on the same edge
//   push, wdata write strobe and data
//   pop, rdata  read strobe; rdata always shows the head word
//   level       number of stored words (0..DEPTH)
//   empty, full status flags
// Strobe semantics: push is accepted only when !full and pop only when
// !empty; a strobe against the wrong flag is dropped. Push and pop on the
// same edge both take effect and leave level unchanged.
module trng_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/trng_multi_src.sv
// trng_multi_src: multi-source ring-oscillator TRNG with register interface.
// Optional feature macro: TRNG_HEALTH_EN (repetition-count health test,
// HFAIL flag and REP_LIMIT register). Without it HFAIL and REP_LIMIT read 0.
// Ports:
//   CLK_I, RESETN_I   clock, asynchronous active-low reset
//   SEL_I, ADDR_I, WRITE_I, WDATA_I  bus access (one per cycle while SEL_I)
//   RDATA_O           registered read data, valid the cycle after a read
//   ENTROPY_I         raw asynchronous ring-oscillator bits
//   SCAN_MODE_I       replaces entropy with a deterministic LFSR
// Registers: 0x0 CTRL, 0x4 STATUS, 0x8 DATA (pops), 0xC REP_LIMIT.
module trng_multi_src
  import trng_pkg::*;
#(
  parameter int         NUM_SRC       = 4,
  parameter int         FIFO_DEPTH    = 8,
  parameter logic [7:0] REP_LIMIT_RST = 8'd32
) (
  input  logic               CLK_I,
  input  logic               RESETN_I,
  input  logic               SEL_I,
  input  logic [31:0]        ADDR_I,
  input  logic               WRITE_I,
  input  logic [31:0]        WDATA_I,
  output logic [31:0]        RDATA_O,
  input  logic [NUM_SRC-1:0] ENTROPY_I,
  input  logic               SCAN_MODE_I
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_SRC-1:0] sync1, sync2;
  logic [15:0]        lfsr;
  logic               raw;

  logic               en, undf, hfail;
  logic               have_a, a_bit;
  logic [WORD_W-1:0]  shift_reg;
  logic [4:0]         bit_cnt;
  logic [7:0]         rep_limit;

  logic [1:0]         addr;
  logic               wr_en, rd_en, clr;
  logic               active, pair_emit, word_done;
  logic               fifo_pop;
  logic [WORD_W-1:0]  fifo_head;
  logic [LW-1:0]      fifo_level;
  logic               fifo_empty, fifo_full;
  logic [31:0]        status_word;
  logic               unused_bits;

  assign addr  = ADDR_I[3:2];
  assign wr_en = SEL_I & WRITE_I;
  assign rd_en = SEL_I & ~WRITE_I;
  assign clr   = wr_en && (addr == ADDR_CTRL) && WDATA_I[CTRL_CLR];

  assign unused_bits = ^{ADDR_I[31:4], ADDR_I[1:0], WDATA_I};

  // Two-flop synchroniser per source; XOR combine after synchronisation.
  always_ff @(posedge CLK_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ENTROPY_I;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge CLK_I or negedge RESETN_I) begin
    if (!RESETN_I)        lfsr <= LFSR_SEED;
    else if (SCAN_MODE_I) lfsr <= lfsr_next(lfsr);
  end

  assign raw = SCAN_MODE_I ? lfsr[0] : ^sync2;

  assign active    = en & ~hfail & ~fifo_full;
  // Second sample of a pair that differs from the first: emit the first.
  assign pair_emit = active & have_a & (a_bit != raw);
  assign word_done = pair_emit & (bit_cnt == 5'd31);
  assign fifo_pop  = rd_en && (addr == ADDR_DATA) && !fifo_empty;

  trng_fifo #(
    .W     (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK_I),
    .rst_n (RESETN_I),
    .flush (clr),
    .push  (word_done),
    .wdata ({shift_reg[WORD_W-2:0], a_bit}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .level (fifo_level),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Debias pair phase and word assembly. Leaving the active state drops a
  // held first bit but keeps the partial word.
  always_ff @(posedge CLK_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      have_a    <= 1'b0;
      a_bit     <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (clr) begin
      have_a    <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (active) begin
      if (!have_a) begin
        have_a <= 1'b1;
        a_bit  <= raw;
      end else begin
        have_a <= 1'b0;
        if (pair_emit) begin
          shift_reg <= {shift_reg[WORD_W-2:0], a_bit};
          bit_cnt   <= bit_cnt + 5'd1;  // wraps to 0 on the word push
        end
      end
    end else begin
      have_a <= 1'b0;
    end
  end

`ifdef TRNG_HEALTH_EN
  logic [7:0] run_cnt, run_next;
  logic       prev_raw;

  // run_cnt == 0 means no previous sample since reset/CLR. Saturates.
  always_comb begin
    run_next = 8'd1;
    if (run_cnt != 8'd0 && raw == prev_raw)
      run_next = (run_cnt == 8'hFF) ? 8'hFF : run_cnt + 8'd1;
  end

  always_ff @(posedge CLK_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      run_cnt   <= '0;
      prev_raw  <= 1'b0;
      hfail     <= 1'b0;
      rep_limit <= REP_LIMIT_RST;
    end else begin
      if (wr_en && addr == ADDR_REP) rep_limit <= WDATA_I[7:0];
      if (clr) begin
        run_cnt  <= '0;
        prev_raw <= 1'b0;
        hfail    <= 1'b0;
      end else if (active) begin
        run_cnt  <= run_next;
        prev_raw <= raw;
        if (rep_limit != 8'd0 && run_next == rep_limit) hfail <= 1'b1;
      end
    end
  end
`else
  assign hfail     = 1'b0;
  assign rep_limit = 8'd0;
`endif

  always_ff @(posedge CLK_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      en   <= 1'b0;
      undf <= 1'b0;
    end else begin
      if (wr_en && addr == ADDR_CTRL) en <= WDATA_I[CTRL_EN];
      if (clr)
        undf <= 1'b0;
      else if (rd_en && addr == ADDR_DATA && fifo_empty)
        undf <= 1'b1;
      else if (wr_en && addr == ADDR_STATUS && WDATA_I[ST_UNDF])
        undf <= 1'b0;
    end
  end

  always_comb begin
    status_word = '0;
    status_word[ST_EMPTY] = fifo_empty;
    status_word[ST_FULL]  = fifo_full;
    status_word[ST_HFAIL] = hfail;
    status_word[ST_UNDF]  = undf;
    status_word[ST_LEVEL_LSB +: 8] = 8'(fifo_level);
  end

  always_ff @(posedge CLK_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      RDATA_O <= '0;
    end else if (rd_en) begin
      case (addr)
        ADDR_CTRL:   RDATA_O <= {31'd0, en};
        ADDR_STATUS: RDATA_O <= status_word;
        ADDR_DATA:   RDATA_O <= fifo_empty ? 32'd0 : fifo_head;
        default:     RDATA_O <= {24'd0, rep_limit};
      endcase
    end
  end

endmodule

// File: tb/tb_trng_multi_src.sv
module tb_trng_multi_src;

  localparam int         NUM_SRC = 4;
  localparam int         DEPTH   = 8;
  localparam logic [7:0] REP_RST = 8'd32;

  logic               CLK_I, RESETN_I, SEL_I, WRITE_I, SCAN_MODE_I;
  logic [31:0]        ADDR_I, WDATA_I, RDATA_O;
  logic [NUM_SRC-1:0] ENTROPY_I;

  trng_multi_src #(
    .NUM_SRC(NUM_SRC), .FIFO_DEPTH(DEPTH), .REP_LIMIT_RST(REP_RST)
  ) dut (
    .CLK_I(CLK_I), .RESETN_I(RESETN_I), .SEL_I(SEL_I), .ADDR_I(ADDR_I),
    .WRITE_I(WRITE_I), .WDATA_I(WDATA_I), .RDATA_O(RDATA_O),
    .ENTROPY_I(ENTROPY_I), .SCAN_MODE_I(SCAN_MODE_I)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK_I = 1'b0;
    forever #5 CLK_I = ~CLK_I;
  end

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  logic [15:0]        m_lfsr = 16'hACE1;
  logic [NUM_SRC-1:0] m_s1 = '0, m_s2 = '0;
  bit                 m_en, m_hfail, m_undf, m_have_a, m_a, m_prev;
  int                 m_bits, m_run;
  logic [31:0]        m_word;
  logic [7:0]         m_rep;
  logic [31:0]        m_fifo[$];
  logic [31:0]        exp_q[$];
  bit                 rd_check;

  function automatic bit push_next();
    logic r;
    r = SCAN_MODE_I ? m_lfsr[0] : ^m_s2;
    return m_en && !m_hfail && (m_fifo.size() < DEPTH) && m_have_a &&
           (r != m_a) && (m_bits == 31);
  endfunction

  always @(posedge CLK_I or negedge RESETN_I) begin : model
    logic        raw, active;
    logic [31:0] rd;
    logic [7:0]  lvl;
    if (!RESETN_I) begin
      m_lfsr = 16'hACE1; m_s1 = '0; m_s2 = '0;
      m_en = 0; m_hfail = 0; m_undf = 0; m_have_a = 0; m_a = 0; m_prev = 0;
      m_bits = 0; m_run = 0; m_word = '0;
`ifdef TRNG_HEALTH_EN
      m_rep = REP_RST;
`else
      m_rep = 8'd0;
`endif
      m_fifo.delete(); exp_q.delete(); rd_check = 0;
    end else begin
      raw    = SCAN_MODE_I ? m_lfsr[0] : ^m_s2;
      active = m_en && !m_hfail && (m_fifo.size() < DEPTH);
      rd_check = 0;
      if (SEL_I && !WRITE_I) begin
        lvl = 8'(m_fifo.size());
        case (ADDR_I[3:2])
          2'd0: rd = {31'd0, m_en};
          2'd1: rd = {16'd0, lvl, 4'd0, m_undf, m_hfail,
                      m_fifo.size() == DEPTH, m_fifo.size() == 0};
          2'd2: if (m_fifo.size() > 0) rd = m_fifo.pop_front();
                else begin rd = 32'd0; m_undf = 1; end
          default: rd = {24'd0, m_rep};
        endcase
        exp_q.push_back(rd);
        rd_check = 1;
      end
      if (active) begin
`ifdef TRNG_HEALTH_EN
        if (m_run == 0 || raw != m_prev) m_run = 1;
        else if (m_run < 255) m_run = m_run + 1;
        m_prev = raw;
        if (m_rep != 0 && m_run == int'(m_rep)) m_hfail = 1;
`endif
        if (!m_have_a) begin
          m_a = raw; m_have_a = 1;
        end else begin
          m_have_a = 0;
          if (m_a != raw) begin
            m_word = {m_word[30:0], m_a};
            m_bits++;
            if (m_bits == 32) begin m_fifo.push_back(m_word); m_bits = 0; end
          end
        end
      end else begin
        m_have_a = 0;
      end
      if (SEL_I && WRITE_I) begin
        case (ADDR_I[3:2])
          2'd0: begin
            m_en = WDATA_I[0];
            if (WDATA_I[1]) begin
              m_fifo.delete(); m_bits = 0; m_word = '0; m_have_a = 0;
              m_run = 0; m_hfail = 0; m_undf = 0;
            end
          end
          2'd1: if (WDATA_I[3]) m_undf = 0;
          2'd3: begin
`ifdef TRNG_HEALTH_EN
            m_rep = WDATA_I[7:0];
`endif
          end
          default: ;
        endcase
      end
      if (SCAN_MODE_I)
        m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
      m_s2 = m_s1;
      m_s1 = ENTROPY_I;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK_I) begin
    logic [31:0] e;
    if (RESETN_I && rd_check) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL scoreboard: read seen with empty expected queue");
      end else begin
        e = exp_q.pop_front();
        check("rdata", RDATA_O, e);
      end
    end
  end

  // ---------------- drivers ----------------
  bit                 ent_hold = 0;
  logic [NUM_SRC-1:0] ent_const = '0;

  initial begin
    logic [31:0] r;
    ENTROPY_I = '0;
    forever begin
      @(negedge CLK_I);
      r = $urandom;
      ENTROPY_I = ent_hold ? ent_const : r[NUM_SRC-1:0];
    end
  end

  task automatic tick();
    @(posedge CLK_I); #1;
  endtask

  task automatic bus(input logic wr, input logic [31:0] addr,
                     input logic [31:0] data);
    @(negedge CLK_I);
    SEL_I = 1'b1; WRITE_I = wr; ADDR_I = addr; WDATA_I = data;
    @(posedge CLK_I); #1;
    SEL_I = 1'b0; WRITE_I = 1'b0;
    ADDR_I = {$urandom} & 32'hFFFF_FFF0; WDATA_I = $urandom;
  endtask

  task automatic timeout(input string name);
    n_checks++; n_errors++;
    $display("FAIL timeout %s: condition not reached within cycle budget", name);
  endtask

  task automatic read_words(input int n, input string name);
    int got = 0, cyc = 0;
    while (got < n && cyc < 20000) begin
      repeat ($urandom_range(8, 24)) begin tick(); cyc++; end
      if (m_fifo.size() > 0) begin bus(1'b0, 32'h8, 32'h0); got++; end
    end
    if (got < n) timeout(name);
  endtask

  // Waits (bounded) until the model reaches a given FIFO level; optionally
  // also until the next edge pushes a word.
  task automatic wait_level(input int lvl, input bit at_push, input string name);
    int cyc = 0;
    while (!(m_fifo.size() == lvl && (!at_push || push_next())) && cyc < 8000) begin
      tick(); cyc++;
    end
    if (!(m_fifo.size() == lvl && (!at_push || push_next()))) timeout(name);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    RESETN_I = 1'b0; SEL_I = 1'b0; WRITE_I = 1'b0; ADDR_I = '0; WDATA_I = '0;
    SCAN_MODE_I = 1'b0;
    repeat (4) @(posedge CLK_I);
    #1 check("rdata_reset", RDATA_O, 32'h0);
    @(negedge CLK_I); RESETN_I = 1'b1;

    // reset register values
    bus(1'b0, 32'h4, 0);
    @(negedge CLK_I); check("status_reset", RDATA_O, 32'h1);
    bus(1'b0, 32'h0, 0);
    bus(1'b0, 32'hC, 0);

    // underflow: empty DATA read returns 0 and sets UNDF; W1C clears it
    bus(1'b0, 32'h8, 0);
    @(negedge CLK_I); check("undf_rdata", RDATA_O, 32'h0);
    bus(1'b0, 32'h4, 0);
    @(negedge CLK_I); check("undf_set", RDATA_O, 32'h9);
    bus(1'b1, 32'h4, 32'h0000_0006);
    bus(1'b0, 32'h4, 0);
    bus(1'b1, 32'h4, 32'h0000_0008);
    bus(1'b0, 32'h4, 0);
    @(negedge CLK_I); check("undf_w1c", RDATA_O, 32'h1);

    // scan mode: 16 words against the LFSR + debias model
    SCAN_MODE_I = 1'b1;
    bus(1'b1, 32'hC, 32'h0);
    bus(1'b1, 32'h0, 32'h1);
    bus(1'b0, 32'h0, 0);
    read_words(16, "scan_words");

    // fill to FULL, sampling stalls, one pop, refill
    wait_level(DEPTH, 1'b0, "fill_full");
    bus(1'b0, 32'h4, 0);
    @(negedge CLK_I); check("full_status", RDATA_O, {16'd0, 8'(DEPTH), 8'h02});
    repeat (200) tick();
    bus(1'b0, 32'h4, 0);
    bus(1'b0, 32'h8, 0);
    bus(1'b0, 32'h4, 0);
    @(negedge CLK_I); check("level_after_pop", {24'd0, RDATA_O[15:8]}, DEPTH - 1);
    wait_level(DEPTH, 1'b0, "refill_full");
    bus(1'b0, 32'h4, 0);

    // pop coinciding with push at level 3
    bus(1'b1, 32'h0, 32'h3);
    wait_level(3, 1'b1, "level3_push");
    bus(1'b0, 32'h8, 0);
    bus(1'b0, 32'h4, 0);
    @(negedge CLK_I); check("pop_push_level", {24'd0, RDATA_O[15:8]}, 32'd3);

    // CLR coinciding with push
    wait_level(3, 1'b1, "clr_push");
    bus(1'b1, 32'h0, 32'h3);
    bus(1'b0, 32'h4, 0);
    @(negedge CLK_I); check("clr_push_status", RDATA_O, 32'h1);

    // random entropy from the sources
    SCAN_MODE_I = 1'b0;
    bus(1'b1, 32'h0, 32'h3);
    read_words(4, "rand_words");
    bus(1'b0, 32'h4, 0);

    // constant entropy: health test trips, no words emitted
    ent_hold = 1; ent_const = 4'b0101;
    repeat (3) tick();
    bus(1'b1, 32'hC, 32'h8);
    bus(1'b1, 32'h0, 32'h3);
    repeat (20) tick();
    bus(1'b0, 32'h4, 0);
`ifdef TRNG_HEALTH_EN
    @(negedge CLK_I); check("hfail_set", RDATA_O, 32'h5);
`else
    @(negedge CLK_I); check("hfail_absent", RDATA_O, 32'h1);
`endif
    bus(1'b0, 32'hC, 0);
    bus(1'b1, 32'h0, 32'h2);
    bus(1'b0, 32'h4, 0);
    @(negedge CLK_I); check("hfail_clr", RDATA_O, 32'h1);

    // reset mid-word at level 2
    ent_hold = 0;
    SCAN_MODE_I = 1'b1;
    bus(1'b1, 32'hC, 32'h0);
    bus(1'b1, 32'h0, 32'h3);
    cyc = 0;
    while (!(m_fifo.size() == 2 && m_bits > 4) && cyc < 8000) begin tick(); cyc++; end
    if (!(m_fifo.size() == 2 && m_bits > 4)) timeout("midword_level2");
    bus(1'b0, 32'h4, 0);
    @(negedge CLK_I); #2 RESETN_I = 1'b0;
    #1 check("rdata_async_reset", RDATA_O, 32'h0);
    repeat (3) @(posedge CLK_I);
    @(negedge CLK_I); RESETN_I = 1'b1;
    bus(1'b0, 32'h4, 0);
    @(negedge CLK_I); check("status_after_reset", RDATA_O, 32'h1);
    bus(1'b0, 32'h0, 0);
    @(negedge CLK_I); check("ctrl_after_reset", RDATA_O, 32'h0);
    bus(1'b0, 32'hC, 0);
`ifdef TRNG_HEALTH_EN
    @(negedge CLK_I); check("rep_after_reset", RDATA_O, {24'd0, REP_RST});
`else
    @(negedge CLK_I); check("rep_after_reset", RDATA_O, 32'h0);
`endif
    bus(1'b0, 32'h8, 0);
    @(negedge CLK_I); check("data_after_reset", RDATA_O, 32'h0);

    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
